daq_uart_packetizer: RTL and testbench
======================================

# daq_uart_packetizer

Parametrised multi-channel sample uplink for the sigma-delta DAQ. Latches decimated samples from N_CH channels, serves pending channels round-robin, frames each sample into a checksummed packet and serialises it on the UART TX line. Sits between the decimation filters and `tx_uart_serial_out` of the top level. Generalises the fixed single-stream TX path with configurable channel count, sample width, parity and stop bits, plus overrun detection.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (≥ 2)
- N_CH, 4, channel count (1..16)
- SAMPLE_W, 24, sample width; multiple of 8, 8..32
- PARITY_EN, 0, 1 inserts parity bit after data bits
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN = 0)
- STOP_BITS, 1, 1 or 2
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  high: packets may start; low: in-flight packet completes, no new one starts
- sample_valid  input  N_CH  one-cycle strobe per channel
- sample_data  input  N_CH*SAMPLE_W  channel k at [k*SAMPLE_W +: SAMPLE_W]
- clr_overrun  input  1  clears all overrun flags
- tx_uart_serial_out  output  1  UART line, idle high
- busy  output  1  high from grant until last stop bit of packet ends
- overrun  output  N_CH  sticky per-channel overrun flags

## Operation
- Reset: tx_uart_serial_out = 1, busy = 0, overrun = 0, all pending/hold cleared, RR pointer = ch0.
- Capture: sample_valid[k] writes hold[k] and sets pending[k].
- Overrun: sample_valid[k] while pending[k] = 1 and ch k not granted that cycle → overrun[k] = 1, hold[k] overwritten (newest wins). Set beats clr_overrun in same cycle.
- Grant same cycle as sample_valid[k]: hold[k] copied to packet register, then new data reloads hold[k], pending[k] stays 1, no overrun.
- Arbitration: round-robin; search starts at channel after last served.
- Packet bytes: 0xA5, {4'h0, ch[3:0]}, SAMPLE_W/8 data bytes MSB first, checksum = XOR of channel byte and all data bytes.
- Byte frame: start 0, 8 data bits LSB first, optional parity, STOP_BITS high; each bit CLKS_PER_BIT cycles.
- FSM: IDLE → (enable & |pending) GRANT → SYNC → CHAN → DATA (SAMPLE_W/8 bytes, byte counter) → CSUM → IDLE.

## Timing
- Start bit of sync byte falls 2 cycles after the edge sampling sample_valid (IDLE, enable = 1, nothing in flight).
- Bytes within a packet back-to-back: next start bit directly follows last stop-bit cycle.
- Between packets exactly 1 extra idle-high cycle (IDLE→GRANT).
- Packet duration: (3 + SAMPLE_W/8) × (10 + PARITY_EN + STOP_BITS − 1) × CLKS_PER_BIT cycles; busy high for exactly this span.
- enable deassert mid-packet: no effect until CSUM done. Reassert: start bit 2 cycles later if pending.
- reset low mid-operation: line forced high asynchronously, packet aborted, never resumed.

## Structure
- Package daq_uart_pkg: packet state enum, SYNC_BYTE = 8'hA5, frame-length helper function.
- Sub-module uart_tx_core: byte serialiser with tx_valid/tx_ready handshake, parameters CLKS_PER_BIT, PARITY_EN, PARITY_ODD, STOP_BITS; tx_ready high in last stop-bit cycle to allow back-to-back bytes.
- Top of block: hold registers, pending/overrun vectors, RR arbiter, packet FSM, checksum accumulator.

## Test plan
Defaults CLKS_PER_BIT = 4, N_CH = 4, SAMPLE_W = 24 unless stated.
- ch2 valid with 0x123456 → bytes A5, 02, 12, 34, 56, 72; start bit 2 cycles after strobe; busy high 240 cycles.
- ch0 and ch3 valid same cycle → ch0 packet, 1 idle cycle, ch3 packet; then ch0 and ch1 valid → ch0 served first.
- During ch0 packet, ch1 valid 0x000001 then 0x000002 → overrun[1] = 1, ch1 packet carries 00 00 02, checksum 03; clr_overrun → overrun = 0.
- PARITY_EN = 1, PARITY_ODD = 0, STOP_BITS = 2 → sync byte frame 0,1,0,1,0,0,1,0,1,0,1,1 (parity 0), 48 cycles per byte.
- reset low during a data byte → line 1 without clock edge, busy 0, overrun 0; after release line stays high with no input.
- enable = 0, ch1 valid 0xABCDEF → no activity; enable = 1 → start bit 2 cycles later, checksum 01^AB^CD^EF = 0x88.

Source files
------------

// File: rtl/daq_uart_pkg.sv
// Shared types and constants for the DAQ UART packetizer: packet FSM states,
// the sync byte and the bits-per-frame helper.
package daq_uart_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_SYNC,
      S_CHAN,
      S_DATA,
      S_CSUM
   } pkt_state_e;

   // Start bit + 8 data bits + optional parity + stop bits.
   function automatic int frame_bits(input int parity_en, input int stop_bits);
      return 9 + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Byte serialiser: start bit, 8 data bits LSB first, optional parity, stop bits.
// tx_ready is asserted in the final stop-bit cycle so bytes can run back to back.
module uart_tx_core
   import daq_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_out
);

   localparam int FB = frame_bits(PARITY_EN, STOP_BITS);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    BIT_LAST = 4'(FB - 1);

   logic [FB-1:0] frame;
   logic [FB-1:0] shreg;
   logic          active;
   logic [CW-1:0] clk_cnt;
   logic [3:0]    bit_cnt;
   logic          last;

   generate
      if (PARITY_EN != 0) begin : g_par
         logic par_bit;
         assign par_bit = (^tx_data) ^ (PARITY_ODD != 0);
         assign frame   = {{STOP_BITS{1'b1}}, par_bit, tx_data, 1'b0};
      end else begin : g_nopar
         assign frame   = {{STOP_BITS{1'b1}}, tx_data, 1'b0};
      end
   endgenerate

   assign last     = active && (bit_cnt == BIT_LAST) && (clk_cnt == CLK_LAST);
   assign tx_ready = !active || last;
   // shreg idles at all-ones, so the line is a plain register bit and reset
   // drives it high without waiting for a clock.
   assign tx_out   = shreg[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg   <= '1;
         active  <= 1'b0;
         clk_cnt <= '0;
         bit_cnt <= '0;
      end else if (tx_valid && tx_ready) begin
         shreg   <= frame;
         active  <= 1'b1;
         clk_cnt <= '0;
         bit_cnt <= '0;
      end else if (active) begin
         if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
               active <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               shreg   <= {1'b1, shreg[FB-1:1]};
            end
         end else begin
            clk_cnt <= clk_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/daq_uart_packetizer.sv
// Multi-channel sample uplink: per-channel hold/pending/overrun, round-robin
// arbitration, packet framing with XOR checksum, UART serialisation.
module daq_uart_packetizer
   import daq_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int N_CH         = 4,
   parameter int SAMPLE_W     = 24,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [N_CH-1:0]          sample_valid,
   input  logic [N_CH*SAMPLE_W-1:0] sample_data,
   input  logic                     clr_overrun,
   output logic                     tx_uart_serial_out,
   output logic                     busy,
   output logic [N_CH-1:0]          overrun
);

   localparam int N_BYTES = SAMPLE_W / 8;
   localparam logic [1:0] BYTE_LAST = 2'(N_BYTES - 1);

   logic [N_CH-1:0][SAMPLE_W-1:0] hold;
   logic [N_CH-1:0]               pending;
   logic [N_CH-1:0]               gnt_vec;
   logic [SAMPLE_W-1:0]           gnt_hold;
   logic [SAMPLE_W-1:0]           pkt_data;
   logic [3:0]                    ptr, gnt_ch, pkt_ch;
   logic                          gnt_found, grant, en_q;
   logic [7:0]                    csum, tx_data, data_byte;
   logic [1:0]                    cnt, cnt_nxt;
   logic                          tx_valid, tx_ready, accept;
   pkt_state_e                    state, state_nxt;

   // Round-robin: first pending channel at or after ptr (ptr = one past last served).
   always_comb begin
      gnt_found = 1'b0;
      gnt_ch    = '0;
      for (int i = 0; i < N_CH; i++) begin
         for (int k = 0; k < N_CH; k++) begin
            if (!gnt_found && pending[k] &&
                (int'(ptr) + i == k || int'(ptr) + i == k + N_CH)) begin
               gnt_found = 1'b1;
               gnt_ch    = 4'(k);
            end
         end
      end
   end

   // A new packet may be granted from idle, or in the last stop-bit cycle of
   // the checksum so consecutive packets are separated by a single idle cycle.
   assign grant  = gnt_found && en_q &&
                   (state == S_IDLE || (state == S_CSUM && tx_ready));
   assign accept = tx_valid && tx_ready;

   always_comb begin
      gnt_vec  = '0;
      gnt_hold = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (gnt_ch == 4'(k)) begin
            gnt_vec[k] = grant;
            gnt_hold   = hold[k];
         end
      end
   end

   always_comb begin
      int sel;
      sel = (state == S_DATA) ? int'(cnt) + 1 : 0;
      if (sel > N_BYTES - 1) sel = N_BYTES - 1;
      data_byte = pkt_data[(N_BYTES-1-sel)*8 +: 8];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Each state names the byte currently on the line and offers the next one.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tx_valid  = 1'b0;
      tx_data   = SYNC_BYTE;
      case (state)
         S_IDLE:  if (grant) state_nxt = S_GRANT;
         S_GRANT: begin
            tx_valid = 1'b1;
            if (tx_ready) state_nxt = S_SYNC;
         end
         S_SYNC: begin
            tx_valid = 1'b1;
            tx_data  = {4'h0, pkt_ch};
            if (tx_ready) state_nxt = S_CHAN;
         end
         S_CHAN: begin
            tx_valid = 1'b1;
            tx_data  = data_byte;
            if (tx_ready) begin
               state_nxt = S_DATA;
               cnt_nxt   = '0;
            end
         end
         S_DATA: begin
            tx_valid = 1'b1;
            if (cnt == BYTE_LAST) begin
               tx_data = csum;
               if (tx_ready) state_nxt = S_CSUM;
            end else begin
               tx_data = data_byte;
               if (tx_ready) cnt_nxt = cnt + 2'd1;
            end
         end
         S_CSUM:  if (tx_ready) state_nxt = grant ? S_GRANT : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold     <= '0;
         pending  <= '0;
         overrun  <= '0;
         en_q     <= 1'b0;
         ptr      <= '0;
         pkt_ch   <= '0;
         pkt_data <= '0;
         csum     <= '0;
         cnt      <= '0;
      end else begin
         en_q <= enable;
         cnt  <= cnt_nxt;
         for (int k = 0; k < N_CH; k++) begin
            if (sample_valid[k]) begin
               hold[k]    <= sample_data[k*SAMPLE_W +: SAMPLE_W];
               pending[k] <= 1'b1;
            end else if (gnt_vec[k]) begin
               pending[k] <= 1'b0;
            end
            if (sample_valid[k] && pending[k] && !gnt_vec[k]) overrun[k] <= 1'b1;
            else if (clr_overrun)                             overrun[k] <= 1'b0;
         end
         if (grant) begin
            pkt_ch   <= gnt_ch;
            pkt_data <= gnt_hold;
            ptr      <= (int'(gnt_ch) == N_CH - 1) ? 4'd0 : gnt_ch + 4'd1;
            csum     <= {4'h0, gnt_ch};
         end else if (accept && (state == S_CHAN ||
                                 (state == S_DATA && cnt != BYTE_LAST))) begin
            csum <= csum ^ tx_data;
         end
      end
   end

   assign busy = (state == S_SYNC) || (state == S_CHAN) ||
                 (state == S_DATA) || (state == S_CSUM);

   uart_tx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .PARITY_EN   (PARITY_EN),
      .PARITY_ODD  (PARITY_ODD),
      .STOP_BITS   (STOP_BITS)
   ) u_tx (
      .clk     (clk),
      .reset   (reset),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .tx_out  (tx_uart_serial_out)
   );

endmodule

// File: tb/tb_daq_uart_packetizer.sv
// Directed bench: table of single-channel packets plus hand sequences for
// arbitration, overrun, parity/stop framing, enable gating and async reset.
module tb_daq_uart_packetizer;

   localparam int CPB = 4;
   localparam int FR  = 40;

   logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, clr_overrun = 1'b0;
   logic [3:0]  sample_valid = '0, valid2 = '0;
   logic [95:0] sample_data = '0;
   logic        tx, busy, tx2, busy2;
   logic [3:0]  overrun, overrun2;

   always #5 clk = ~clk;

   daq_uart_packetizer #(.CLKS_PER_BIT(CPB), .N_CH(4), .SAMPLE_W(24),
                         .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
      .sample_data(sample_data), .clr_overrun(clr_overrun),
      .tx_uart_serial_out(tx), .busy(busy), .overrun(overrun));

   daq_uart_packetizer #(.CLKS_PER_BIT(CPB), .N_CH(4), .SAMPLE_W(24),
                         .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_par (
      .clk(clk), .reset(reset), .enable(enable), .sample_valid(valid2),
      .sample_data(sample_data), .clr_overrun(clr_overrun),
      .tx_uart_serial_out(tx2), .busy(busy2), .overrun(overrun2));

   typedef struct {
      int          ch;
      logic [23:0] data;
      logic [47:0] exp;
   } vec_t;

   vec_t vecs [4];
   int   checks = 0, errors = 0;
   logic ln [0:1023], bz [0:1023], ln2 [0:1023], bz2 [0:1023];
   int   widx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sample();
      @(negedge clk);
      if (widx < 1024) begin
         ln[widx] = tx;  bz[widx] = busy;
         ln2[widx] = tx2; bz2[widx] = busy2;
         widx++;
      end
   endtask

   // Called with strobes already driven: checks the two idle-high cycles
   // before the start bit, then arms capture so sample index 0 is the start bit.
   task automatic launch(input string name);
      @(negedge clk);
      sample_valid = '0;
      valid2       = '0;
      chk({name, " idle1"}, 32'({tx, tx2}), 32'b11);
      @(negedge clk);
      chk({name, " idle2"}, 32'({tx, tx2, busy}), 32'b110);
      widx = 0;
   endtask

   function automatic logic [7:0] rx_byte(input int base);
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = ln[base + (1 + i) * CPB + 2];
      return v;
   endfunction

   function automatic int busy_cnt(input int n, input bit second);
      int c = 0;
      for (int i = 0; i < n; i++) c += second ? int'(bz2[i]) : int'(bz[i]);
      return c;
   endfunction

   initial begin
      logic [11:0] f;
      int          bad;

      vecs[0] = '{2, 24'h123456, 48'hA50212345672};
      vecs[1] = '{3, 24'h000000, 48'hA50300000003};
      vecs[2] = '{0, 24'hFFFFFF, 48'hA500FFFFFFFF};
      vecs[3] = '{1, 24'h800001, 48'hA50180000180};

      repeat (3) @(negedge clk);
      chk("reset line", 32'({tx, tx2}), 32'b11);
      chk("reset busy", 32'({busy, busy2}), 32'b00);
      chk("reset overrun", 32'({overrun, overrun2}), 32'h00);
      reset  = 1'b1;
      enable = 1'b1;
      repeat (2) @(negedge clk);

      // Parity + 2 stop bits: 12-bit frames, 48 cycles per byte.
      sample_data[23:0] = 24'h123456;
      valid2 = 4'b0001;
      launch("par");
      repeat (289) sample();
      for (int j = 0; j < 12; j++) f[j] = ln2[j * CPB + 2];
      chk("par sync frame", 32'(f), 32'hD4A);
      chk("par byte spacing", 32'({ln2[47], ln2[48]}), 32'b10);
      chk("par busy span", busy_cnt(289, 1'b1), 288);
      repeat (2) @(negedge clk);

      // Two channels in the same cycle: ch0 first, one idle cycle, then ch3.
      sample_data[23:0]  = 24'h010203;
      sample_data[95:72] = 24'h0A0B0C;
      sample_valid = 4'b1001;
      launch("rr1");
      repeat (481) sample();
      chk("rr1 first chan", 32'(rx_byte(FR)), 32'h00);
      chk("rr1 first csum", 32'(rx_byte(5 * FR)), 32'h00);
      chk("rr1 gap", 32'({ln[239], ln[240], ln[241], bz[240]}), 32'b1100);
      chk("rr1 second chan", 32'(rx_byte(241 + FR)), 32'h03);
      chk("rr1 second data0", 32'(rx_byte(241 + 2 * FR)), 32'h0A);
      chk("rr1 second csum", 32'(rx_byte(241 + 5 * FR)), 32'h0E);
      repeat (2) @(negedge clk);

      sample_data[23:0]  = 24'h000000;
      sample_data[47:24] = 24'h000000;
      sample_valid = 4'b0011;
      launch("rr2");
      repeat (481) sample();
      chk("rr2 first chan", 32'(rx_byte(FR)), 32'h00);
      chk("rr2 second chan", 32'(rx_byte(241 + FR)), 32'h01);
      repeat (2) @(negedge clk);

      // Table of single-channel packets.
      for (int v = 0; v < 4; v++) begin
         sample_data[vecs[v].ch * 24 +: 24] = vecs[v].data;
         sample_valid = 4'(1 << vecs[v].ch);
         launch($sformatf("vec%0d", v));
         repeat (241) sample();
         chk($sformatf("vec%0d start", v), 32'(ln[0]), 32'b0);
         for (int b = 0; b < 6; b++)
            chk($sformatf("vec%0d byte%0d", v, b), 32'(rx_byte(b * FR)),
                32'(vecs[v].exp[47 - 8 * b -: 8]));
         chk($sformatf("vec%0d busy span", v), busy_cnt(241, 1'b0), 240);
      end
      repeat (2) @(negedge clk);

      // Overrun: ch1 strobed twice while ch0 is on the line; newest data wins.
      sample_data[23:0] = 24'h111111;
      sample_valid = 4'b0001;
      launch("ovr");
      for (int t = 0; t < 481; t++) begin
         sample();
         sample_valid = '0;
         if (t == 10) begin sample_data[47:24] = 24'h000001; sample_valid = 4'b0010; end
         if (t == 30) begin sample_data[47:24] = 24'h000002; sample_valid = 4'b0010; end
      end
      chk("ovr ch0 csum", 32'(rx_byte(5 * FR)), 32'h11);
      chk("ovr ch1 chan", 32'(rx_byte(241 + FR)), 32'h01);
      chk("ovr ch1 data", 32'({rx_byte(241 + 2 * FR), rx_byte(241 + 3 * FR), rx_byte(241 + 4 * FR)}),
          32'h000002);
      chk("ovr ch1 csum", 32'(rx_byte(241 + 5 * FR)), 32'h03);
      chk("ovr flag", 32'(overrun), 32'b0010);
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      chk("ovr cleared", 32'(overrun), 32'b0000);
      repeat (2) @(negedge clk);

      // Enable gating: pending sample waits until enable returns.
      enable = 1'b0;
      sample_data[47:24] = 24'hABCDEF;
      sample_valid = 4'b0010;
      @(negedge clk);
      sample_valid = '0;
      widx = 0;
      repeat (20) sample();
      bad = 0;
      for (int i = 0; i < 20; i++) bad += int'(!ln[i]) + int'(bz[i]);
      chk("en0 quiet", bad, 0);
      enable = 1'b1;
      launch("en1");
      repeat (241) sample();
      chk("en1 start", 32'(ln[0]), 32'b0);
      chk("en1 chan", 32'(rx_byte(FR)), 32'h01);
      chk("en1 csum", 32'(rx_byte(5 * FR)), 32'h88);
      repeat (2) @(negedge clk);

      // Async reset while a data byte's start bit is on the line.
      sample_data[71:48] = 24'h123456;
      sample_valid = 4'b0100;
      launch("rst");
      for (int t = 0; t < 82; t++) begin
         sample();
         sample_valid = '0;
         if (t == 10 || t == 20) begin sample_data[47:24] = 24'h000007; sample_valid = 4'b0010; end
      end
      chk("rst pre line", 32'(ln[81]), 32'b0);
      chk("rst pre overrun", 32'(overrun), 32'b0010);
      #1 reset = 1'b0;
      #1;
      chk("rst line async", 32'(tx), 32'b1);
      chk("rst busy", 32'(busy), 32'b0);
      chk("rst overrun", 32'(overrun), 32'b0000);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      widx = 0;
      repeat (300) sample();
      bad = 0;
      for (int i = 0; i < 300; i++) bad += int'(!ln[i]) + int'(bz[i]);
      chk("rst no resume", bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
